// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared types and constants for the 4x8 RAM sequencer
package ram_ctrl_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        WAIT_RD = 2'd2,
        DONE    = 2'd3
    } state_t;

    // ram_rd idles high so a stray CS can never be seen as a write
    localparam logic IDLE_CS = 1'b0;
    localparam logic IDLE_RD = 1'b1;
    localparam logic IDLE_OE = 1'b0;

endpackage

// File: rtl/ram4x8_arbiter_if.sv
// rtl/ram4x8_arbiter_if.sv - requester ports and RAM pins of the sequencer
interface ram4x8_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              ram_cs;
    logic              ram_rd;
    logic              ram_oe;
    logic [ADDR_W-1:0] ram_endereco;
    logic [DATA_W-1:0] ram_entrada;
    logic [DATA_W-1:0] ram_saida;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_saida,
        output ack0, ack1, rdata, busy, ram_cs, ram_rd, ram_oe, ram_endereco, ram_entrada
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_saida,
        input  ack0, ack1, rdata, busy, ram_cs, ram_rd, ram_oe, ram_endereco, ram_entrada
    );
endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-port round-robin pick
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);
    always_comb begin
        grant_valid = |req;
        grant_idx   = 1'b0;
        if (req == 2'b11) begin
            grant_idx = ~last_grant;
        end else begin
            grant_idx = req[1];
        end
    end
endmodule

// File: rtl/ram4x8_arbiter.sv
// rtl/ram4x8_arbiter.sv - serialises two requesters onto the 4x8 RAM pin protocol
module ram4x8_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    ram4x8_arbiter_if.slave  bus
);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              idx_q, idx_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              cs_q, cs_d;
    logic              rd_q, rd_d;
    logic              oe_q, oe_d;
    logic [ADDR_W-1:0] endereco_q, endereco_d;
    logic [DATA_W-1:0] entrada_q, entrada_d;

    logic              grant_valid;
    logic              grant_idx;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    rr_arbiter2 u_arb (
        .req         ({bus.req1, bus.req0}),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        win_we    = grant_idx ? bus.we1    : bus.we0;
        win_addr  = grant_idx ? bus.addr1  : bus.addr0;
        win_wdata = grant_idx ? bus.wdata1 : bus.wdata0;
    end

    // Pin values are computed for the state being entered so every output is a flop
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        idx_d        = idx_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        endereco_d   = endereco_q;
        entrada_d    = entrada_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        cs_d         = IDLE_CS;
        rd_d         = IDLE_RD;
        oe_d         = IDLE_OE;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d      = ACCESS;
                    idx_d        = grant_idx;
                    last_grant_d = grant_idx;
                    we_d         = win_we;
                    addr_d       = win_addr;
                    wdata_d      = win_wdata;
                    cs_d         = 1'b1;
                    rd_d         = ~win_we;
                    oe_d         = ~win_we;
                    endereco_d   = win_addr;
                    entrada_d    = win_wdata;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = DONE;
                    ack0_d  = ~idx_q;
                    ack1_d  = idx_q;
                end else begin
                    state_d    = WAIT_RD;
                    cs_d       = 1'b1;
                    rd_d       = 1'b1;
                    oe_d       = 1'b1;
                    endereco_d = addr_q;
                end
            end
            WAIT_RD: begin
                state_d = DONE;
                rdata_d = bus.ram_saida;
                ack0_d  = ~idx_q;
                ack1_d  = idx_q;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            idx_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata_q      <= '0;
            busy_q       <= 1'b0;
            cs_q         <= IDLE_CS;
            rd_q         <= IDLE_RD;
            oe_q         <= IDLE_OE;
            endereco_q   <= '0;
            entrada_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            idx_q        <= idx_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata_q      <= rdata_d;
            busy_q       <= busy_d;
            cs_q         <= cs_d;
            rd_q         <= rd_d;
            oe_q         <= oe_d;
            endereco_q   <= endereco_d;
            entrada_q    <= entrada_d;
        end
    end

    assign bus.ack0         = ack0_q;
    assign bus.ack1         = ack1_q;
    assign bus.rdata        = rdata_q;
    assign bus.busy         = busy_q;
    assign bus.ram_cs       = cs_q;
    assign bus.ram_rd       = rd_q;
    assign bus.ram_oe       = oe_q;
    assign bus.ram_endereco = endereco_q;
    assign bus.ram_entrada  = entrada_q;

endmodule

// File: doc/ram4x8_arbiter.md
# ram4x8_arbiter

Sequencer and two-port round-robin arbiter for the 4x8 synchronous RAM. Two requesters (instruction fetch and data path) each issue single-word read or write requests. The block serialises these into the RAM's CS/RD/OE/address/data protocol and captures read data, then returns a one-cycle acknowledge to the winning requester. The block owns the RAM control pins; nothing else drives them.

## Interface
- DATA_W, default 8, word width; must match the RAM.
- ADDR_W, default 2, address width; must match the RAM.
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high.
- req0, req1  in  1  level request per port; held until that port's ack.
- we0, we1  in  1  1 = write, 0 = read; stable while req is high.
- addr0, addr1  in  ADDR_W  word address; stable while req is high.
- wdata0, wdata1  in  DATA_W  write data; stable while req is high.
- ack0, ack1  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  read result, shared; valid in the cycle ack of a read is high.
- busy  out  1  high in every state except IDLE.
- ram_cs, ram_rd, ram_oe  out  1  to RAM CS, RD and OE.
- ram_endereco  out  ADDR_W  to RAM address.
- ram_entrada  out  DATA_W  to RAM write data.
- ram_saida  in  DATA_W  from RAM read data.

## Operation
- FSM states: IDLE, ACCESS, WAIT_RD, DONE.
- IDLE
  - When any req is high, the arbiter picks a winner.
  - The winner's we, addr and wdata are latched, and the winner's index is stored.
  - Next state is ACCESS.
  - With no request, the FSM stays in IDLE.
- Arbitration is round-robin over two ports.
  - With a single requester, that requester wins.
  - With both requesting, the port not granted last wins.
  - last_grant updates only on a grant.
- ACCESS
  - ram_cs = 1, ram_rd = !we, ram_oe = !we.
  - ram_endereco and ram_entrada come from the latched values.
  - The RAM performs the access at the edge ending this cycle.
  - Next state: DONE for a write, WAIT_RD for a read.
- WAIT_RD
  - ram_cs = ram_rd = ram_oe = 1 and the address is held, so ram_saida stays stable.
  - ram_saida is registered into rdata at the edge ending this cycle.
  - Next state is DONE.
- DONE
  - The winner's ack pulses high for exactly one cycle; the other ack stays 0.
  - RAM pins return to idle values.
  - Next state is IDLE.
- In IDLE and DONE the RAM pins hold idle values: ram_cs = 0, ram_rd = 1, ram_oe = 0. ram_rd idles high so no spurious write can occur.
- A requester that keeps req high after its ack is treated as issuing a new request, sampled in the following IDLE cycle.
- rdata holds its last read value until the next read completes; writes do not change it.
- Ports with req low are ignored. we, addr and wdata are don't-care while req is low.

## Timing
- Reset values:
  - State IDLE, last_grant = 1, so port 0 wins first.
  - ack0 = ack1 = 0, busy = 0, rdata = 0.
  - ram_cs = 0, ram_rd = 1, ram_oe = 0, ram_endereco = 0, ram_entrada = 0.
- Latency, with req sampled high in IDLE at edge t:
  - Write: ACCESS in cycle t+1, ack in cycle t+2.
  - Read: ACCESS in t+1, WAIT_RD in t+2, ack with valid rdata in t+3.
- Throughput: one request per 3 cycles (write) or 4 cycles (read), because IDLE is revisited between requests.
- If both ports request continuously, grants alternate 0,1,0,1…
- All outputs are registered; there is no combinational path from req to ram_* pins or to ack.
- Reset mid-operation: the FSM returns to IDLE and no ack is issued. If reset is asserted at the edge ending an ACCESS write, the RAM write may still commit.
- A request arriving while busy waits; it is never dropped and never aborts the current access.

## Structure
- Shared package `ram_ctrl_pkg` holds:
  - The state enum (IDLE, ACCESS, WAIT_RD, DONE).
  - DATA_W and ADDR_W defaults.
  - Idle pin constants: CS 0, RD 1, OE 0.
- One sub-module, `rr_arbiter2`, has inputs req[1:0] and last_grant, and outputs grant_valid and grant_idx. It is combinational, with last_grant registered in the parent.
- The top level contains the FSM, the request latch, the rdata register and the pin drivers.

## Test plan
- After reset, check ram_cs = 0, ram_rd = 1, ack = 0, busy = 0. Then req0 writes 8'hA5 to address 2: ram_cs = 1, ram_rd = 0, ram_endereco = 2, ram_entrada = A5 in cycle t+1, and ack0 in t+2.
- req1 reads address 2 after that write: ack1 in t+3 with rdata = 8'hA5, and ram_oe = 1 during ACCESS and WAIT_RD.
- req0 and req1 both held high with distinct addresses for 8 grants: acks alternate 0,1,0,1…, each ack is exactly one cycle, and the first winner is port 0.
- Write 11, 22, 33, 44 to addresses 0–3, then read them back: values are returned in order and address 3 wraps cleanly with no aliasing.
- Assert reset during WAIT_RD of a read: no ack, FSM back in IDLE, RAM pins idle on the next cycle. A subsequent request completes normally with correct latency.
